// File: rtl/mem_fill_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_fill_responder
//  Brief    : Word-storage responder for cache fills; single writes, single
//             reads and line-fill bursts with a fixed access latency.
//  Revision : 1.0 - initial release
// ============================================================================

module mem_fill_responder #(
    parameter int LATENCY   = 4,
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_burst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_last,
    output logic              busy
);

    localparam int c_BEAT_W    = $clog2(BURST_LEN) + 1;
    localparam int c_MEM_WORDS = 2 ** (ADDR_W - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_BURST = 2'd2;

    localparam logic [3:0]          c_LAT_LOAD   = 4'(LATENCY - 1);
    localparam logic [c_BEAT_W-1:0] c_BURST_LAST = c_BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0]   c_LINE_MASK  = ~ADDR_W'(2 * BURST_LEN - 1);
    localparam logic [ADDR_W-1:0]   c_WORD_MASK  = ~ADDR_W'(1);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [3:0]          r_lat_cnt;
    logic [c_BEAT_W-1:0] r_beat;
    logic [c_BEAT_W-1:0] r_last_beat;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_hold_addr;
    logic [DATA_W-1:0]   r_hold_data;
    logic [DATA_W-1:0]   r_mem [c_MEM_WORDS];

    logic                w_idle;
    logic                w_rd_accept;
    logic                w_wr_accept;
    logic                w_present;
    logic                w_is_last;
    logic [ADDR_W-1:0]   w_cur_addr;
    logic [DATA_W-1:0]   w_rd_data;

    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_rd_accept = w_idle && req_valid && !req_wr;
    assign w_wr_accept = w_idle && req_valid && req_wr;

    // The first word goes out in the last WAIT cycle, so the initiator sees
    // it exactly LATENCY edges after acceptance.
    assign w_present  = ((r_state == c_ST_WAIT) && (r_lat_cnt == 4'd0)) ||
                        (r_state == c_ST_BURST);
    assign w_is_last  = w_present && (r_beat == r_last_beat);
    assign w_cur_addr = r_base + ADDR_W'({r_beat, 1'b0});
    assign w_rd_data  = r_mem[w_cur_addr[ADDR_W-1:1]];

    // State register and transaction counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_lat_cnt   <= '0;
            r_beat      <= '0;
            r_last_beat <= '0;
            r_base      <= '0;
            r_hold_addr <= '0;
            r_hold_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_rd_accept) begin
                r_lat_cnt   <= c_LAT_LOAD;
                r_beat      <= '0;
                r_base      <= req_burst ? (req_addr & c_LINE_MASK) : (req_addr & c_WORD_MASK);
                r_last_beat <= req_burst ? c_BURST_LAST : '0;
            end else if ((r_state == c_ST_WAIT) && (r_lat_cnt != 4'd0)) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end
            if (w_present) begin
                r_beat      <= r_beat + 1'b1;
                r_hold_addr <= w_cur_addr;
                r_hold_data <= w_rd_data;
            end
        end
    end

    // Storage is deliberately left out of reset so contents survive an abort.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_accept) begin
            r_mem[req_addr[ADDR_W-1:1]] <= req_wdata;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_rd_accept) begin
                    w_next_state = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (r_lat_cnt == 4'd0) begin
                    w_next_state = w_is_last ? c_ST_IDLE : c_ST_BURST;
                end
            end
            c_ST_BURST: begin
                if (w_is_last) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = w_idle;
        busy      = (r_state == c_ST_WAIT) || (r_state == c_ST_BURST);
        rsp_valid = w_present;
        rsp_last  = w_is_last;
        if (w_present) begin
            rsp_addr = w_cur_addr;
            rsp_data = w_rd_data;
        end else begin
            rsp_addr = r_hold_addr;
            rsp_data = r_hold_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_fill_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_fill_responder
//  Brief    : Self-checking bench: directed vector table, corner sequences and
//             randomized traffic against a word-array reference model.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_mem_fill_responder;

    localparam int LATENCY   = 4;
    localparam int BURST_LEN = 8;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_wr = 1'b0;
    logic              req_burst = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_last;
    logic              busy;

    int n_pass  = 0;
    int n_total = 0;

    // Reference storage keyed by word index; absent keys were never written.
    logic [DATA_W-1:0] model_mem [int];

    typedef struct {
        bit          wr;
        bit          burst;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
        int          exp_beats;
    } vec_t;

    mem_fill_responder #(
        .LATENCY  (LATENCY),
        .BURST_LEN(BURST_LEN),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr   (req_wr),
        .req_burst(req_burst),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_addr (rsp_addr),
        .rsp_last (rsp_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drives one request until accepted; for reads, checks the latency gap,
    // every beat against the model, and the return to idle.
    task automatic do_req(input bit wr, input bit burst, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic [15:0] first_addr,
                          output logic [15:0] first_data, output int beats);
        bit          ok;
        int          pre_bad;
        int          n;
        logic [15:0] base;
        logic [15:0] last_a;
        first_addr = '0;
        first_data = '0;
        beats      = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_wr = wr; req_burst = burst; req_addr = addr; req_wdata = wdata;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        check("accept", {63'b0, ok}, 64'd1);
        if (!ok) begin req_valid = 1'b0; return; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (wr) begin
            model_mem[int'(addr >> 1)] = wdata;
            return;
        end
        base   = burst ? (addr & ~16'(2 * BURST_LEN - 1)) : (addr & 16'hFFFE);
        n      = burst ? BURST_LEN : 1;
        last_a = base;
        pre_bad = 0;
        for (int i = 0; i < LATENCY - 1; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) pre_bad++;
        end
        check("latency_gap", 64'(pre_bad), 64'd0);
        for (int k = 0; k < n; k++) begin
            logic [15:0] a;
            logic [15:0] d;
            bit          known;
            a      = base + 16'(2 * k);
            last_a = a;
            known  = model_mem.exists(int'(a >> 1));
            d      = known ? model_mem[int'(a >> 1)] : 16'h0;
            @(negedge clk);
            if (k == 0) begin first_addr = rsp_addr; first_data = rsp_data; end
            if (rsp_valid) beats++;
            check($sformatf("beat%0d@%h", k, a),
                  {30'b0, rsp_valid, rsp_last, rsp_addr, known ? rsp_data : 16'h0},
                  {30'b0, 1'b1, 1'(k == n - 1), a, d});
        end
        @(negedge clk);
        check("ready_after_last", {45'b0, req_ready, rsp_valid, busy, rsp_addr},
              {45'b0, 3'b100, last_a});
    endtask

    initial begin
        vec_t        tbl [16];
        logic [15:0] fa;
        logic [15:0] fd;
        int          nb;
        int          beats;
        int          last_at;
        int          extra;
        bit          ready_seen;

        tbl[0]  = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0, 16'h0, 0};
        tbl[1]  = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0010, 16'hBEEF, 1};
        for (int i = 0; i < 8; i++)
            tbl[2 + i] = '{1'b1, 1'b0, 16'(16'h0020 + 2 * i), 16'(16'h1000 + i), 16'h0, 16'h0, 0};
        tbl[10] = '{1'b0, 1'b1, 16'h0026, 16'h0000, 16'h0020, 16'h1000, 8};
        tbl[11] = '{1'b1, 1'b0, 16'hFFF0, 16'hA0A0, 16'h0, 16'h0, 0};
        tbl[12] = '{1'b1, 1'b0, 16'hFFFE, 16'hAFAF, 16'h0, 16'h0, 0};
        tbl[13] = '{1'b0, 1'b1, 16'hFFF4, 16'h0000, 16'hFFF0, 16'hA0A0, 8};
        tbl[14] = '{1'b0, 1'b0, 16'h002F, 16'h0000, 16'h002E, 16'h1007, 1};
        tbl[15] = '{1'b0, 1'b1, 16'h002E, 16'h0000, 16'h0020, 16'h1000, 8};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", {28'b0, rsp_valid, req_ready, busy, rsp_last, rsp_addr, rsp_data},
              {28'b0, 4'b0100, 16'h0, 16'h0});

        for (int i = 0; i < 16; i++) begin
            do_req(tbl[i].wr, tbl[i].burst, tbl[i].addr, tbl[i].wdata, fa, fd, nb);
            if (!tbl[i].wr)
                check($sformatf("vec%0d", i), {fa, fd, 32'(nb)},
                      {tbl[i].exp_addr, tbl[i].exp_data, 32'(tbl[i].exp_beats)});
        end

        // A write held pending through a burst is taken only once idle again.
        do_req(1'b1, 1'b0, 16'h0040, 16'h1111, fa, fd, nb);
        @(posedge clk); #1;
        req_valid = 1'b1; req_wr = 1'b0; req_burst = 1'b1; req_addr = 16'h0020;
        ready_seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req_ready) begin ready_seen = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_wr = 1'b1; req_burst = 1'b0; req_addr = 16'h0040; req_wdata = 16'h5555;
        beats = 0; last_at = 0; ready_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin ready_seen = 1'b1; break; end
            if (rsp_valid) beats++;
            if (rsp_valid && rsp_last) last_at = beats;
        end
        check("held_write_blocked", {31'b0, ready_seen, 16'(beats), 16'(last_at)},
              {31'b0, 1'b1, 16'd8, 16'd8});
        @(posedge clk); #1;
        req_valid = 1'b0; req_wr = 1'b0;
        model_mem[int'(16'h0040 >> 1)] = 16'h5555;
        do_req(1'b0, 1'b0, 16'h0040, 16'h0, fa, fd, nb);
        check("held_write_value", {48'b0, fd}, {48'b0, 16'h5555});

        // Reset during the third beat of a burst aborts the transfer.
        @(posedge clk); #1;
        req_valid = 1'b1; req_wr = 1'b0; req_burst = 1'b1; req_addr = 16'h0020;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        beats = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) beats++;
            if (beats == 3) break;
        end
        check("third_beat_reached", 64'(beats), 64'd3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_abort", {29'b0, rsp_valid, req_ready, busy, rsp_addr, rsp_data},
              {29'b0, 3'b010, 16'h0, 16'h0});
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) extra++;
        end
        check("no_beats_after_reset", 64'(extra), 64'd0);
        do_req(1'b0, 1'b0, 16'h0024, 16'h0, fa, fd, nb);
        check("read_after_abort", {fa, fd, 32'(nb)}, {16'h0024, 16'h1002, 32'd1});

        // Randomized traffic in a preloaded window.
        for (int i = 0; i < 128; i++)
            do_req(1'b1, 1'b0, 16'(16'h0100 + 2 * i), 16'($urandom), fa, fd, nb);
        for (int i = 0; i < 40; i++) begin
            bit          rw;
            bit          rb;
            logic [15:0] ra;
            rw = ($urandom_range(0, 2) == 0);
            rb = 1'($urandom_range(0, 1));
            ra = 16'(16'h0100 + $urandom_range(0, 255));
            do_req(rw, rb, ra, 16'($urandom), fa, fd, nb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule

`default_nettype wire
